// File: rtl/painterengine_gpu_pkg.sv
// rtl/painterengine_gpu_pkg.sv - shared pixel format constants and packing helper for the GPU converters
package painterengine_gpu_pkg;

  // Input stream byte order
  localparam logic IRGB_RGB = 1'b0;
  localparam logic IRGB_BGR = 1'b1;

  // Output pixel packing, MSB to LSB
  localparam logic [1:0] OARGB_ARGB = 2'd0;
  localparam logic [1:0] OARGB_ABGR = 2'd1;
  localparam logic [1:0] OARGB_RGBA = 2'd2;
  localparam logic [1:0] OARGB_BGRA = 2'd3;

  // Place the four channels into a 32-bit word according to the output mode
  function automatic logic [31:0] pack_pixel(input logic [7:0] a, input logic [7:0] r,
                                             input logic [7:0] g, input logic [7:0] b,
                                             input logic [1:0] mode);
    logic [31:0] px;
    case (mode)
      OARGB_ARGB: px = {a, r, g, b};
      OARGB_ABGR: px = {a, b, g, r};
      OARGB_RGBA: px = {r, g, b, a};
      default:    px = {b, g, r, a};
    endcase
    return px;
  endfunction

endpackage

// File: rtl/painterengine_gpu_byte_ring.sv
// rtl/painterengine_gpu_byte_ring.sv - 8-entry byte ring with 4-byte write port and 3-byte read port
module painterengine_gpu_byte_ring
  import painterengine_gpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [31:0] wdata_i,
  input  logic        pop_i,
  output logic [3:0]  count_o,
  output logic [7:0]  b0_o,
  output logic [7:0]  b1_o,
  output logic [7:0]  b2_o
);

  logic [7:0] mem_q [8];
  logic [2:0] wr_q, wr_d;
  logic [2:0] rd_q, rd_d;
  logic [3:0] count_q, count_d;

  // 3-bit pointer offsets wrap modulo 8 by construction
  logic [2:0] wr1, wr2, wr3, rd1, rd2;
  assign wr1 = wr_q + 3'd1;
  assign wr2 = wr_q + 3'd2;
  assign wr3 = wr_q + 3'd3;
  assign rd1 = rd_q + 3'd1;
  assign rd2 = rd_q + 3'd2;

  assign count_o = count_q;
  assign b0_o    = mem_q[rd_q];
  assign b1_o    = mem_q[rd1];
  assign b2_o    = mem_q[rd2];

  // Next pointers and occupancy; clear wins over any push or pop this cycle
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clear_i) begin
      wr_d    = 3'd0;
      rd_d    = 3'd0;
      count_d = 4'd0;
    end else begin
      if (push_i) wr_d = wr_q + 3'd4;
      if (pop_i)  rd_d = rd_q + 3'd3;
      count_d = count_q + (push_i ? 4'd4 : 4'd0) - (pop_i ? 4'd3 : 4'd0);
    end
  end

  // Pointer and occupancy registers, lost immediately on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= 3'd0;
      rd_q    <= 3'd0;
      count_q <= 4'd0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Byte storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      mem_q[wr_q] <= wdata_i[7:0];
      mem_q[wr1]  <= wdata_i[15:8];
      mem_q[wr2]  <= wdata_i[23:16];
      mem_q[wr3]  <= wdata_i[31:24];
    end
  end

endmodule

// File: rtl/painterengine_gpu_rgb2argb.sv
// rtl/painterengine_gpu_rgb2argb.sv - unpacks 24-bit packed RGB words into 32-bit ARGB pixels
module painterengine_gpu_rgb2argb
  import painterengine_gpu_pkg::*;
#(
  parameter logic [7:0] ALPHA = 8'hFF
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_clear,
  input  logic [31:0] i_wire_data,
  input  logic        i_wire_valid,
  output logic        o_wire_ready,
  input  logic        i_wire_irgb_mode,
  input  logic [1:0]  i_wire_oargb_mode,
  output logic [31:0] o_wire_argb,
  output logic        o_wire_valid,
  input  logic        i_wire_ready
);

  logic [3:0]  count;
  logic [7:0]  b0, b1, b2;
  logic [7:0]  r, g, b;
  logic        push, pop;
  logic [31:0] argb_q, argb_d;
  logic        valid_q, valid_d;

  // Room for a whole word is judged on the registered count only, so no
  // path exists from the output handshake back to the input ready
  assign o_wire_ready = !i_wire_reset && (count <= 4'd4) && !i_wire_clear;
  assign push         = i_wire_valid && o_wire_ready;
  assign pop          = (count >= 4'd3) && (!valid_q || i_wire_ready) && !i_wire_clear;

  assign r = (i_wire_irgb_mode == IRGB_BGR) ? b2 : b0;
  assign g = b1;
  assign b = (i_wire_irgb_mode == IRGB_BGR) ? b0 : b2;

  assign o_wire_argb  = argb_q;
  assign o_wire_valid = valid_q;

  painterengine_gpu_byte_ring u_ring (
    .clk_i   (i_wire_clock),
    .rst_i   (i_wire_reset),
    .clear_i (i_wire_clear),
    .push_i  (push),
    .wdata_i (i_wire_data),
    .pop_i   (pop),
    .count_o (count),
    .b0_o    (b0),
    .b1_o    (b1),
    .b2_o    (b2)
  );

  // Output register next state: load on pop, empty when consumed, else hold
  always_comb begin
    argb_d  = argb_q;
    valid_d = valid_q;
    if (i_wire_clear) begin
      argb_d  = 32'd0;
      valid_d = 1'b0;
    end else if (pop) begin
      argb_d  = pack_pixel(ALPHA, r, g, b, i_wire_oargb_mode);
      valid_d = 1'b1;
    end else if (i_wire_ready) begin
      argb_d  = 32'd0;
      valid_d = 1'b0;
    end
  end

  // Output pixel register
  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      argb_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      argb_q  <= argb_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_rgb2argb.sv
// tb/tb_painterengine_gpu_rgb2argb.sv - self-checking bench for the packed RGB to ARGB unpacker
module tb_painterengine_gpu_rgb2argb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] i_data = 32'd0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        irgb = 1'b0;
  logic [1:0]  oargb = 2'd0;
  logic [31:0] o_argb;
  logic        o_valid;
  logic        i_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] in_words[$];
  logic [31:0] got[$];
  int          idx;
  bit          prev_stall;
  logic [31:0] prev_argb;

  painterengine_gpu_rgb2argb #(.ALPHA(8'hFF)) dut (
    .i_wire_clock      (clk),
    .i_wire_reset      (rst),
    .i_wire_clear      (clr),
    .i_wire_data       (i_data),
    .i_wire_valid      (i_valid),
    .o_wire_ready      (o_ready),
    .i_wire_irgb_mode  (irgb),
    .i_wire_oargb_mode (oargb),
    .o_wire_argb       (o_argb),
    .o_wire_valid      (o_valid),
    .i_wire_ready      (i_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_at(input int i);
    logic [31:0] w;
    w = in_words[i / 4];
    return 8'((w >> (8 * (i % 4))) & 32'hFF);
  endfunction

  function automatic logic [31:0] ref_pix(input logic [7:0] x0, input logic [7:0] x1,
                                          input logic [7:0] x2, input logic im, input logic [1:0] om);
    int rr, gg, bb, aa;
    rr = im ? x2 : x0;
    gg = x1;
    bb = im ? x0 : x2;
    aa = 255;
    case (om)
      2'd0:    return 32'(aa * 16777216 + rr * 65536 + gg * 256 + bb);
      2'd1:    return 32'(aa * 16777216 + bb * 65536 + gg * 256 + rr);
      2'd2:    return 32'(rr * 16777216 + gg * 65536 + bb * 256 + aa);
      default: return 32'(bb * 16777216 + gg * 65536 + rr * 256 + aa);
    endcase
  endfunction

  // One cycle: drive at the falling edge, observe 1 ns later, account for the coming rising edge
  task automatic step(input int n, input int vpct, input int rpct);
    @(negedge clk);
    i_data  = (idx < n) ? in_words[idx] : 32'd0;
    i_valid = (idx < n) && ($urandom_range(99) < vpct);
    i_ready = ($urandom_range(99) < rpct);
    #1;
    if (prev_stall) begin
      total++;
      if (o_valid !== 1'b1 || o_argb !== prev_argb) begin
        bad++;
        $display("FAIL stall_hold: valid=%b argb=%h required valid=1 argb=%h", o_valid, o_argb, prev_argb);
      end
    end
    total++;
    if (dut.u_ring.count_o > 4'd8) begin
      bad++;
      $display("FAIL count_range: count=%0d required <=8", dut.u_ring.count_o);
    end
    if (i_valid && o_ready) idx++;
    if (o_valid && i_ready) got.push_back(o_argb);
    prev_stall = o_valid && !i_ready;
    prev_argb  = o_argb;
  endtask

  task automatic stream(input int n, input int vpct, input int rpct, input int exp_n, input int max_cyc);
    int cyc;
    got.delete();
    idx = 0;
    prev_stall = 1'b0;
    cyc = 0;
    while ((idx < n || got.size() < exp_n) && cyc < max_cyc) begin
      step(n, vpct, rpct);
      cyc++;
    end
    if (cyc >= max_cyc) begin
      total++;
      bad++;
      $display("FAIL stream_timeout: accepted=%0d pixels=%0d required words=%0d pixels=%0d", idx, got.size(), n, exp_n);
    end
    for (int k = 0; k < 4; k++) step(n, 0, 100);
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if (o_valid !== 1'b0 || o_argb !== 32'd0 || o_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b argb=%h ready=%b required 0 0 0", o_valid, o_argb, o_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: ready=%b required 1", o_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_px [4];
    exp_px = '{32'hFF112233, 32'hFF445566, 32'hFF778899, 32'hFFAABBCC};
    in_words = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
    irgb = 1'b0;
    oargb = 2'd0;
    stream(3, 100, 100, 4, 100);
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL basic_count: pixels=%0d required 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      total++;
      if (got[k] !== exp_px[k]) begin
        bad++;
        $display("FAIL basic_pixel%0d: got %h required %h", k, got[k], exp_px[k]);
      end
    end
  endtask

  task automatic test_modes();
    logic        im [4];
    logic [1:0]  om [4];
    logic [31:0] ex [4];
    im = '{1'b1, 1'b0, 1'b0, 1'b0};
    om = '{2'd0, 2'd2, 2'd3, 2'd1};
    ex = '{32'hFF332211, 32'h112233FF, 32'h332211FF, 32'hFF332211};
    for (int t = 0; t < 4; t++) begin
      in_words = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
      irgb = im[t];
      oargb = om[t];
      stream(3, 100, 100, 4, 100);
      total++;
      if (got.size() < 1 || got[0] !== ex[t]) begin
        bad++;
        $display("FAIL mode_irgb%0d_oargb%0d: got %h required %h", im[t], om[t],
                 (got.size() > 0) ? got[0] : 32'hx, ex[t]);
      end
    end
    irgb = 1'b0;
    oargb = 2'd0;
  endtask

  task automatic test_wraparound();
    in_words.delete();
    for (int w = 0; w < 6; w++)
      in_words.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    stream(6, 100, 100, 8, 200);
    total++;
    if (got.size() != 8) begin
      bad++;
      $display("FAIL wrap_count: pixels=%0d required 8", got.size());
    end
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      total++;
      if (got[k] !== ref_pix(8'(3*k), 8'(3*k+1), 8'(3*k+2), 1'b0, 2'd0)) begin
        bad++;
        $display("FAIL wrap_pixel%0d: got %h required %h", k, got[k],
                 ref_pix(8'(3*k), 8'(3*k+1), 8'(3*k+2), 1'b0, 2'd0));
      end
    end
    total++;
    if (got.size() == 8 && got[7] !== 32'hFF151617) begin
      bad++;
      $display("FAIL wrap_last: got %h required ff151617", got[7]);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    in_words.delete();
    for (int w = 0; w < 6; w++)
      in_words.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    got.delete();
    idx = 0;
    prev_stall = 1'b0;
    for (int c = 0; c < 10; c++) step(6, 100, 0);
    total++;
    if (o_valid !== 1'b1 || o_argb !== 32'hFF000102) begin
      bad++;
      $display("FAIL bp_frozen: valid=%b argb=%h required 1 ff000102", o_valid, o_argb);
    end
    total++;
    if (idx != 2 || o_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready: accepted=%0d ready=%b required 2 0", idx, o_ready);
    end
    cyc = 0;
    while ((idx < 6 || got.size() < 8) && cyc < 200) begin
      step(6, 100, 100);
      cyc++;
    end
    for (int k = 0; k < 4; k++) step(6, 0, 100);
    total++;
    if (got.size() != 8) begin
      bad++;
      $display("FAIL bp_count: pixels=%0d required 8", got.size());
    end
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      total++;
      if (got[k] !== ref_pix(8'(3*k), 8'(3*k+1), 8'(3*k+2), 1'b0, 2'd0)) begin
        bad++;
        $display("FAIL bp_pixel%0d: got %h required %h", k, got[k],
                 ref_pix(8'(3*k), 8'(3*k+1), 8'(3*k+2), 1'b0, 2'd0));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    in_words.delete();
    for (int w = 0; w < 300; w++) in_words.push_back($urandom());
    irgb = 1'($urandom_range(1));
    oargb = 2'($urandom_range(3));
    for (int k = 0; k < 400; k++)
      exp_q.push_back(ref_pix(byte_at(3*k), byte_at(3*k+1), byte_at(3*k+2), irgb, oargb));
    stream(300, 70, 60, 400, 20000);
    total++;
    if (got.size() != 400) begin
      bad++;
      $display("FAIL random_count: pixels=%0d required 400", got.size());
    end
    for (int k = 0; k < 400 && k < got.size(); k++) begin
      total++;
      if (got[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL random_pixel%0d: got %h required %h", k, got[k], exp_q[k]);
      end
    end
    irgb = 1'b0;
    oargb = 2'd0;
  endtask

  task automatic test_clear_residue();
    in_words = '{32'h44332211};
    stream(1, 100, 100, 1, 100);
    total++;
    if (got.size() != 1 || got[0] !== 32'hFF112233) begin
      bad++;
      $display("FAIL clear_first: pixels=%0d first=%h required 1 ff112233", got.size(),
               (got.size() > 0) ? got[0] : 32'hx);
    end
    @(negedge clk);
    clr = 1'b1;
    i_valid = 1'b1;
    i_data = 32'hDEADBEEF;
    #1;
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_ready: ready=%b required 0", o_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    i_valid = 1'b0;
    in_words = '{32'h88776655};
    stream(1, 100, 100, 1, 100);
    total++;
    if (got.size() != 1 || got[0] !== 32'hFF556677) begin
      bad++;
      $display("FAIL clear_after: pixels=%0d first=%h required 1 ff556677", got.size(),
               (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h44332211;
    for (int c = 0; c < 3; c++) @(negedge clk);
    i_valid = 1'b0;
    #1;
    total++;
    if (o_valid !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre: valid=%b required 1", o_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_argb !== 32'd0) begin
      bad++;
      $display("FAIL areset_now: valid=%b argb=%h required 0 0", o_valid, o_argb);
    end
    @(negedge clk);
    rst = 1'b0;
    in_words = '{32'h44332211};
    stream(1, 100, 100, 1, 100);
    total++;
    if (got.size() != 1 || got[0] !== 32'hFF112233) begin
      bad++;
      $display("FAIL areset_after: pixels=%0d first=%h required 1 ff112233", got.size(),
               (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_wraparound();
    test_backpressure();
    test_random();
    test_clear_residue();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
